// File: rtl/pll_lock_seq_pkg.sv
// pll_seq_pkg: shared definitions for the rPLL lock sequencer.
// Holds the FSM state encodings, the retry counter width and the
// state-to-output decode used by pll_lock_seq.
package pll_seq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  typedef struct packed {
    logic pll_reset;
    logic sys_rst_n;
    logic fail;
  } seq_out_t;

  // Output pattern owned by each state. It is applied to the state being
  // entered, so the outputs change on the same edge as the transition.
  function automatic seq_out_t decode_outputs(pll_state_e s);
    seq_out_t o;
    o.pll_reset = (s == PLL_RST) || (s == FAIL);
    o.sys_rst_n = (s == RUN);
    o.fail      = (s == FAIL);
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// pll_lock_seq_if: signals between the lock sequencer and the rPLL wrapper.
// The master side is the sequencer, the slave side is the PLL wrapper.
// With PLL_PHASE_STEP_EN defined the PSDA phase-select bus is carried too.
interface pll_lock_seq_if;

  logic pll_lock;
  logic pll_reset;
  logic pll_reset_p;

`ifdef PLL_PHASE_STEP_EN
  logic [3:0] psda;

  modport master (input pll_lock, output pll_reset, output pll_reset_p, output psda);
  modport slave  (output pll_lock, input pll_reset, input pll_reset_p, input psda);
`else
  modport master (input pll_lock, output pll_reset, output pll_reset_p);
  modport slave  (output pll_lock, input pll_reset, input pll_reset_p);
`endif

endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser for the asynchronous PLL LOCK pin,
// cleared asynchronously so lock reads as low throughout reset.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the pin through two flops before anything in clk uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flops sample their old inputs on the same
      // edge; blocking here would collapse the chain into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: reset and lock sequencer for the fabric rPLL.
// Pulses the PLL reset, waits for LOCK, qualifies it as stable, releases
// the system reset and re-locks on loss of lock. Consecutive lock timeouts
// are bounded; exhausting them parks the sequencer in FAIL until relock_req.
// Optional build macro PLL_PHASE_STEP_EN adds PSDA phase stepping while in RUN.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_lock_seq_if.master     pll,
  input  logic               relock_req,
  output logic               sys_rst_n,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
`ifdef PLL_PHASE_STEP_EN
  ,
  input  logic               phase_inc,
  output logic               phase_busy
`endif
);

  // Terminal counts; every compare is against the value before increment.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  logic               lock_s;
  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  seq_out_t           out_q;

  pll_lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll.pll_lock),
    .q     (lock_s)
  );

  // Cannot wrap: the FSM leaves WAIT_LOCK once the count reaches MAX_RETRY.
  assign retry_inc = retry_q + RETRY_W'(1);

  // Next-state, counter and retry rules; the counter restarts on every entry.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? FAIL : PLL_RST;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        // A dropout restarts the timeout but is not a retry.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss and an explicit request take the same path.
        if (relock_req || !lock_s) state_d = PLL_RST;
      end
      FAIL: begin
        cnt_d = '0;
        if (relock_req) begin
          state_d = PLL_RST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= decode_outputs(PLL_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  // RESET and RESET_P are driven together from one flop.
  assign pll.pll_reset   = out_q.pll_reset;
  assign pll.pll_reset_p = out_q.pll_reset;
  assign sys_rst_n       = out_q.sys_rst_n;
  assign fail            = out_q.fail;
  assign retry_cnt       = retry_q;
  assign state           = state_q;

`ifdef PLL_PHASE_STEP_EN
  logic [3:0] psda_q;
  logic [2:0] busy_cnt_q;
  logic       busy_q;

  // One PSDA step per accepted request, then eight busy cycles. PSDA is only
  // cleared by rst_n, so the phase setting survives a re-lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psda_q     <= '0;
      busy_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else if (busy_q) begin
      if (busy_cnt_q == 3'd0) busy_q <= 1'b0;
      else                    busy_cnt_q <= busy_cnt_q - 3'd1;
    end else if (state_q == RUN && phase_inc) begin
      psda_q     <= psda_q + 4'd1;
      busy_q     <= 1'b1;
      busy_cnt_q <= 3'd7;
    end
  end

  assign pll.psda   = psda_q;
  assign phase_busy = busy_q;
`endif

endmodule
